muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It implements the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It runs beside the single-cycle ALU. The pipeline holds PC, IF/ID and ID/EX while the unit computes, and the result reaches EX/MEM with its rd tag.

Parameters:
XLEN, 32, operand/result width; even, >=8
UNROLL, 1, radix-2 steps per clock; must divide XLEN (1, 2, 4, 8)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  request; sampled only in IDLE or DONE
op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  in  XLEN  operand A (multiplicand/dividend)
rs2_i  in  XLEN  operand B (multiplier/divisor)
rd_i  in  5  destination tag
flush_i  in  1  abort in-flight operation (branch/flush)
busy_o  out  1  high in CALC and FIXUP; drives hazard stall
done_o  out  1  one-cycle pulse, result valid
result_o  out  XLEN  result; held until next accept
rd_o  out  5  tag of result_o; held with result_o

Behaviour:
- Reset (rst_i=0, async): state IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0; internal accumulators cleared. This applies mid-operation too, with no done_o.
- States: IDLE, CALC, FIXUP, DONE. Let N = XLEN/UNROLL.
- Accept: an edge with state in {IDLE, DONE}, start_i=1 and flush_i=0 latches op, operands (as magnitudes) and sign flags and loads the rd tag. The next state is CALC, or DONE on the special cases below.
- CALC: UNROLL shift-add (mul) or restoring-subtract (div) steps per clock, with a step counter. After N clocks the next state is FIXUP.
- FIXUP: one clock. Applies the sign correction (two's-complement negate of the 2*XLEN product or of quotient/remainder) and selects the low half, high half, quotient or remainder into result_o.
- DONE: done_o=1 for exactly this cycle. If start_i is sampled here, the next operation is accepted back-to-back; otherwise the state returns to IDLE.
- Latency: done_o is high N+2 cycles after the accepting edge (34 for default parameters).
- Signedness: MULH treats both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. DIV and REM are signed. The remainder takes the sign of the dividend.
- Special cases are resolved at accept, skip CALC/FIXUP, and assert done_o 1 cycle after accept:
  - divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV with rs1 = 2^(XLEN-1) and rs2 = -1: quotient = rs1; REM gives 0.
- Multiply has no special-case shortcut.
- start_i in CALC/FIXUP is ignored, with no queuing. The pipeline must not issue while busy_o=1.
- flush_i=1 in CALC/FIXUP: the next state is IDLE, done_o is not asserted, and result_o/rd_o keep their previous values.
- flush_i=1 in IDLE/DONE blocks the accept; flush wins over start. A done_o already high in the flush cycle stays high because the result is delivered.
- All arithmetic is modulo 2^XLEN (product 2*XLEN). There are no exceptions and no overflow flags.

Decomposition:
- Shared package muldiv_pkg: op encoding constants (funct3 values), state typedef, helper predicates is_div/is_signed_a/is_signed_b.
- One sub-module muldiv_step: combinational, performs UNROLL iterations of shift-add or restoring-divide on {acc, operand} per call. It is instantiated once; muldiv_unit owns the FSM, counter, sign fixup and registers.

Test Plan:
1. Multiply, default params: MUL 7,-3 (0xFFFFFFFD) -> done_o at accept+34, result_o=0xFFFFFFEB, rd_o=rd_i; busy_o=1 for cycles +1..+33.
2. High multiplies:
   - MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE
   - MULH 0x80000000,0x80000000 -> 0x40000000
   - MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF
3. Divides:
   - DIV -7,2 -> 0xFFFFFFFD
   - REM -7,2 -> 0xFFFFFFFF
   - DIVU 100,7 -> 0x0000000E
   - REMU 100,7 -> 0x00000002
   - back-to-back start in DONE cycle accepted, second result correct at +34 from its accept.
4. Special cases:
   - DIV 5,0 -> 0xFFFFFFFF, done_o at accept+1, busy_o never high
   - REMU 5,0 -> 5
   - DIV 0x80000000,0xFFFFFFFF -> 0x80000000
   - REM same operands -> 0
5. Flush: flush_i at accept+10 -> busy_o=0 next cycle, no done_o, result_o unchanged. start_i+flush_i together in IDLE -> not accepted. start_i while busy ignored and the result is for the first op.
6. Reset and UNROLL: rst_i low at accept+5 -> busy_o/done_o/result_o = 0 immediately, no done_o after release. UNROLL=4: MUL 7,-3 done_o at accept+10, result 0xFFFFFFEB.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state type and op predicates for muldiv_unit
package muldiv_pkg;

    // funct3 encodings of the RV32M operations
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // REM/REMU select the remainder; DIV/DIVU the quotient
    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - UNROLL radix-2 shift-add / restoring-divide iterations on {acc, opa}
//
// Ports:
//   div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i  : upper half (partial product high / partial remainder)
//   opa_i  : lower half (multiplier bits / dividend bits, filling with product low / quotient)
//   opb_i  : multiplicand or divisor magnitude
//   acc_o, opa_o : state after UNROLL iterations
module muldiv_step #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] opa_o
);

    always_comb begin
        logic [XLEN-1:0] acc;
        logic [XLEN-1:0] opa;
        logic [XLEN:0]   sum;
        logic [XLEN:0]   rem;
        logic [XLEN:0]   diff;
        acc  = acc_i;
        opa  = opa_i;
        sum  = '0;
        rem  = '0;
        diff = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (div_i) begin
                // Shifted remainder is below 2*divisor, so bit XLEN of the
                // difference is set exactly when the subtraction borrows.
                rem  = {acc, opa[XLEN-1]};
                diff = rem - {1'b0, opb_i};
                opa  = {opa[XLEN-2:0], ~diff[XLEN]};
                acc  = diff[XLEN] ? rem[XLEN-1:0] : diff[XLEN-1:0];
            end else begin
                // Add multiplicand when the current multiplier bit is set, then
                // shift the whole {carry, acc, opa} right by one.
                sum = {1'b0, acc} + {1'b0, {XLEN{opa[0]}} & opb_i};
                opa = {sum[0], opa[XLEN-1:1]};
                acc = sum[XLEN:1];
            end
        end
        acc_o = acc;
        opa_o = opa;
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i, op_i, rs1_i, rs2_i, rd_i : request, accepted in IDLE or DONE
//   flush_i  : abort in-flight op / block an accept
//   busy_o   : high in CALC and FIXUP
//   done_o   : one-cycle result-valid pulse
//   result_o, rd_o : result and its tag, held until replaced
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_pend_q, rd_pend_d;

    logic [XLEN-1:0]   step_acc, step_opa;

    muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .opa_i (opa_q),
        .opb_i (opb_q),
        .acc_o (step_acc),
        .opa_o (step_opa)
    );

    always_comb begin
        logic              sa, sb, dbz, ovf;
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   dval, fix_res;

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        rd_d      = rd_q;
        rd_pend_d = rd_pend_q;

        sa  = is_signed_a(op_i) & rs1_i[XLEN-1];
        sb  = is_signed_b(op_i) & rs2_i[XLEN-1];
        dbz = (rs2_i == '0);
        ovf = ((op_i == OP_DIV) || (op_i == OP_REM))
              && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

        // Sign correction works on magnitudes: negate the full product, or the
        // selected quotient/remainder, when the latched sign flag says so.
        prod = {acc_q, opa_q};
        if (neg_q) prod = -prod;
        dval = is_rem(op_q) ? acc_q : opa_q;
        if (neg_q) dval = -dval;
        if (is_div(op_q))        fix_res = dval;
        else if (op_q == OP_MUL) fix_res = prod[XLEN-1:0];
        else                     fix_res = prod[2*XLEN-1:XLEN];

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i && !flush_i) begin
                    op_d      = op_i;
                    rd_pend_d = rd_i;
                    cnt_d     = '0;
                    acc_d     = '0;
                    opa_d     = sa ? -rs1_i : rs1_i;
                    opb_d     = sb ? -rs2_i : rs2_i;
                    // Remainder follows the dividend; everything else the operand xor.
                    neg_d     = is_rem(op_i) ? sa : (sa ^ sb);
                    if (is_div(op_i) && (dbz || ovf)) begin
                        state_d  = ST_DONE;
                        rd_d     = rd_i;
                        if (dbz) result_d = op_i[1] ? rs1_i : '1;
                        else     result_d = op_i[1] ? '0 : rs1_i;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    opa_d = step_opa;
                    if (cnt_q == CW'(N - 1)) state_d = ST_FIXUP;
                    else                     cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_FIXUP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fix_res;
                    rd_d     = rd_pend_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            rd_pend_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIXUP);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (default and UNROLL=4 instances)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start4 = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;
    logic        busy, done, busy4, done4;
    logic [31:0] result, result4;
    logic [4:0]  rdo, rdo4;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t sb[$];
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .rd_i(rd), .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result), .rd_o(rdo)
    );

    muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .rd_i(rd), .flush_i(flush), .busy_o(busy4), .done_o(done4), .result_o(result4), .rd_o(rdo4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics with plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        int sa, sbv;
        sa = a;
        sbv = b;
        case (o)
            3'd0: return a * b;
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sbv;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sbv;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: every done_o pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result 0x%08h expected no done_o", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_tag", {27'd0, rdo}, {27'd0, e.rd});
                check("latency", cyc - e.acc_cyc + 1, e.lat);
                last_res = e.res;
                last_rd  = e.rd;
            end
        end
    end

    // Called at a negedge while the DUT is in IDLE or DONE.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit expect_it);
        exp_t e;
        op = o; rs1 = a; rs2 = b; rd = t; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (expect_it) begin
            e.res = model(o, a, b);
            e.rd = t;
            e.acc_cyc = cyc;
            e.lat = is_special(o, a, b) ? 1 : 34;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int nbusy);
        bit seen = 0;
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
            if (busy) nbusy++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done_o expected done_o within 200 cycles");
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
        int nb;
        issue(o, a, b, t, 1'b1);
        wait_done(nb);
        check("busy_cycles", nb, is_special(o, a, b) ? 0 : 33);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        int c0;
        bit seen;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'd0, rdo}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed ops; consecutive run_op calls issue back-to-back in the DONE cycle.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        @(negedge clk);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd5, 32'd100, 32'd7, 5'd7);
        run_op(3'd7, 32'd100, 32'd7, 5'd8);
        run_op(3'd4, 32'd5, 32'd0, 5'd9);
        run_op(3'd7, 32'd5, 32'd0, 5'd10);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        @(negedge clk);

        // Randomized ops, with and without idle gaps.
        for (int i = 0; i < 120; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 7));
            run_op(ro, pick_val(), pick_val(), 5'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        // Flush at accept+10: no done_o, outputs keep the last delivered result.
        issue(3'd5, 32'd12345, 32'd17, 5'd21, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_held", result, last_res);
        check("flush_rd_held", {27'd0, rdo}, {27'd0, last_rd});
        repeat (40) @(negedge clk);

        // start together with flush in IDLE is not accepted.
        op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd22; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("start_flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // start while busy is ignored; result belongs to the first op.
        issue(3'd0, 32'd11, 32'd13, 5'd23, 1'b1);
        repeat (5) @(negedge clk);
        op = 3'd5; rs1 = 32'd99; rs2 = 32'd0; rd = 5'd24; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(nb);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd", {27'd0, rdo}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // UNROLL=4 instance: latency N+2 = 10.
        op = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; rd = 5'd26; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        c0 = cyc;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done4) begin seen = 1; break; end
        end
        check("u4_done_seen", {31'd0, seen}, 32'd1);
        check("u4_latency", cyc - c0 + 1, 32'd10);
        check("u4_result", result4, model(3'd0, 32'd7, 32'hFFFF_FFFD));
        check("u4_rd", {27'd0, rdo4}, 32'd26);
        @(negedge clk);
        op = 3'd6; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; rd = 5'd27; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done4) begin seen = 1; break; end
        end
        check("u4_rem_seen", {31'd0, seen}, 32'd1);
        check("u4_rem_result", result4, model(3'd6, 32'hFFFF_FF9C, 32'd7));

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
